ex_muldiv: RTL and testbench



---
 rtl/ex_muldiv_if.sv | 29 ++
 rtl/ex_muldiv.sv | 190 +++++++++++++++++++
 tb/tb_ex_muldiv.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// Handshake and result bundle between the EX stage and the iterative multiply/divide unit.
// The master side is the pipeline and the slave side is the unit.
interface ex_muldiv_if #(
    parameter int XLEN      = 32,
    parameter int REGADDR_W = 5
);
    logic                 start_i;
    logic [2:0]           op_i;
    logic [XLEN-1:0]      opr1_i;
    logic [XLEN-1:0]      opr2_i;
    logic [REGADDR_W-1:0] wd_i;
    logic                 wreg_i;
    logic                 flush_i;
    logic                 ex_stall_o;
    logic                 done_o;
    logic [REGADDR_W-1:0] wd_o;
    logic                 wreg_o;
    logic [XLEN-1:0]      wdata_o;

    modport master (
        output start_i, op_i, opr1_i, opr2_i, wd_i, wreg_i, flush_i,
        input  ex_stall_o, done_o, wd_o, wreg_o, wdata_o
    );

    modport slave (
        input  start_i, op_i, opr1_i, opr2_i, wd_i, wreg_i, flush_i,
        output ex_stall_o, done_o, wd_o, wreg_o, wdata_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on operand magnitudes,
// with sign fix-up after the loop and single-cycle resolution of trivial cases.
//
// state | meaning
// IDLE  | waiting for start_i; trivial cases resolve here straight to DONE
// CALC  | XLEN shift-add (multiply) or restoring shift-subtract (divide) steps
// FIX   | sign correction and result select
// DONE  | result presented for one cycle, pipeline released
module ex_muldiv #(
    parameter int XLEN      = 32,
    parameter int REGADDR_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    ex_muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           op_q;
    logic                 neg_q;
    logic                 neg_rem_q;
    logic [XLEN-1:0]      mag_b;
    logic [XLEN-1:0]      acc_hi;
    logic [XLEN-1:0]      acc_lo;
    logic [REGADDR_W-1:0] wd_q;
    logic                 wreg_q;
    logic                 done_q;
    logic [REGADDR_W-1:0] wd_r;
    logic [XLEN-1:0]      wdata_r;

    logic                 a_signed;
    logic                 b_signed;
    logic                 a_neg;
    logic                 b_neg;
    logic [XLEN-1:0]      a_mag;
    logic [XLEN-1:0]      b_mag;
    logic                 div_zero;
    logic                 div_ovf;
    logic                 mul_zero;
    logic                 special;
    logic [XLEN-1:0]      special_res;

    always_comb begin
        a_signed = (bus.op_i == OP_MULH) || (bus.op_i == OP_MULHSU) ||
                   (bus.op_i == OP_DIV)  || (bus.op_i == OP_REM);
        b_signed = (bus.op_i == OP_MULH) || (bus.op_i == OP_DIV) || (bus.op_i == OP_REM);
        a_neg    = a_signed & bus.opr1_i[XLEN-1];
        b_neg    = b_signed & bus.opr2_i[XLEN-1];
        a_mag    = a_neg ? (~bus.opr1_i + XLEN'(1)) : bus.opr1_i;
        b_mag    = b_neg ? (~bus.opr2_i + XLEN'(1)) : bus.opr2_i;

        div_zero = bus.op_i[2] && (bus.opr2_i == '0);
        div_ovf  = ((bus.op_i == OP_DIV) || (bus.op_i == OP_REM)) &&
                   (bus.opr1_i == MOST_NEG) && (bus.opr2_i == '1);
        mul_zero = !bus.op_i[2] && ((bus.opr1_i == '0) || (bus.opr2_i == '0));
        special  = div_zero || div_ovf || mul_zero;

        special_res = '0;
        if (div_zero) begin
            special_res = bus.op_i[1] ? bus.opr1_i : '1;
        end else if (div_ovf) begin
            special_res = bus.op_i[1] ? '0 : bus.opr1_i;
        end
    end

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_sub;
    logic            div_ge;
    logic            lo_zero;
    logic [XLEN-1:0] fix_res;

    // Partial remainder stays below the divisor, so the XLEN+1-bit difference
    // never overflows and its top bit is a clean borrow.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : {(XLEN+1){1'b0}});
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_sub   = div_shift - {1'b0, mag_b};
        div_ge    = ~div_sub[XLEN];
        lo_zero   = (acc_lo == '0);

        // High-half negation of the 2*XLEN product: the +1 only carries in
        // when the low half is all zeros.
        if (!op_q[2]) begin
            if (op_q[1:0] == 2'b00) begin
                fix_res = acc_lo;
            end else begin
                fix_res = neg_q ? (~acc_hi + XLEN'(lo_zero)) : acc_hi;
            end
        end else if (!op_q[1]) begin
            fix_res = neg_q ? (~acc_lo + XLEN'(1)) : acc_lo;
        end else begin
            fix_res = neg_rem_q ? (~acc_hi + XLEN'(1)) : acc_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            mag_b     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            wd_q      <= '0;
            wreg_q    <= 1'b0;
            done_q    <= 1'b0;
            wd_r      <= '0;
            wdata_r   <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush_i) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start_i) begin
                            op_q      <= bus.op_i;
                            neg_q     <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            mag_b     <= b_mag;
                            acc_hi    <= '0;
                            acc_lo    <= a_mag;
                            wd_q      <= bus.wd_i;
                            wreg_q    <= bus.wreg_i;
                            if (special) begin
                                wdata_r <= special_res;
                                wd_r    <= bus.wd_i;
                                done_q  <= 1'b1;
                                state   <= S_DONE;
                            end else begin
                                cnt   <= CNT_W'(XLEN - 1);
                                state <= S_CALC;
                            end
                        end
                    end
                    S_CALC: begin
                        if (op_q[2]) begin
                            acc_hi <= div_ge ? div_sub[XLEN-1:0] : div_shift[XLEN-1:0];
                            acc_lo <= {acc_lo[XLEN-2:0], div_ge};
                        end else begin
                            acc_hi <= mul_sum[XLEN:1];
                            acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                        end
                        if (cnt == '0) begin
                            state <= S_FIX;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    S_FIX: begin
                        wdata_r <= fix_res;
                        wd_r    <= wd_q;
                        done_q  <= 1'b1;
                        state   <= S_DONE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.ex_stall_o = (state == S_CALC) || (state == S_FIX) ||
                            ((state == S_IDLE) && bus.start_i);
    assign bus.done_o     = done_q;
    assign bus.wreg_o     = done_q & wreg_q & ~bus.flush_i;
    assign bus.wd_o       = wd_r;
    assign bus.wdata_o    = wdata_r;
endmodule

// File: tb/tb_ex_muldiv.sv
// Randomised and directed bench for ex_muldiv; expected results come from
// 64-bit integer arithmetic and a start/done timeline per operation.
module tb_ex_muldiv;
    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ex_muldiv_if #(.XLEN(XLEN), .REGADDR_W(RW)) bus ();

    ex_muldiv #(.XLEN(XLEN), .REGADDR_W(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Expected-operation record and held-output model
    bit              pend_live = 0;
    int              pend_start, pend_done, op_start;
    logic [31:0]     pend_data;
    logic [RW-1:0]   pend_wd;
    logic            pend_wreg;
    logic [31:0]     last_wdata = '0;
    logic [RW-1:0]   last_wd = '0;
    int              done_seen_cyc = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic void ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] res, output bit special);
        longint      sa, sb, ua, ub, q;
        logic [63:0] p;
        bit          ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        res = '0;
        special = 0;
        case (op)
            3'd0: begin p = ua * ub; res = p[31:0];  special = (a == 0) || (b == 0); end
            3'd1: begin p = sa * sb; res = p[63:32]; special = (a == 0) || (b == 0); end
            3'd2: begin p = sa * ub; res = p[63:32]; special = (a == 0) || (b == 0); end
            3'd3: begin p = ua * ub; res = p[63:32]; special = (a == 0) || (b == 0); end
            3'd4: begin
                special = (b == 0) || ovf;
                if (b == 0) res = 32'hFFFF_FFFF;
                else if (ovf) res = a;
                else begin q = sa / sb; res = q[31:0]; end
            end
            3'd5: begin special = (b == 0); res = (b == 0) ? 32'hFFFF_FFFF : a / b; end
            3'd6: begin
                special = (b == 0) || ovf;
                if (b == 0) res = a;
                else if (ovf) res = 0;
                else begin q = sa % sb; res = q[31:0]; end
            end
            default: begin special = (b == 0); res = (b == 0) ? a : a % b; end
        endcase
    endfunction

    // Per-cycle compare against the operation timeline and held outputs
    initial forever begin
        bit exp_done, exp_stall;
        @(negedge clk);
        #2;
        if (!rst) begin
            exp_done  = pend_live && (cyc == pend_done);
            exp_stall = pend_live ? (cyc >= pend_start && cyc < pend_done) : bus.start_i;
            chk("done", bus.done_o, exp_done);
            chk("stall", bus.ex_stall_o, exp_stall);
            if (exp_done) begin
                last_wdata    = pend_data;
                last_wd       = pend_wd;
                pend_live     = 0;
                done_seen_cyc = cyc;
                chk("wreg", bus.wreg_o, pend_wreg && !bus.flush_i);
            end else begin
                chk("wreg_idle", bus.wreg_o, 1'b0);
            end
            chk("wdata", bus.wdata_o, last_wdata);
            chk("wd", bus.wd_o, last_wd);
        end
    end

    // mode: 0 plain, 1 hold start_i until done, 2 flush at relative cycle k, 3 reset at k
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [RW-1:0] wd, input logic wreg, input int mode, input int k);
        logic [31:0] res;
        bit          sp;
        int          kk;
        @(negedge clk);
        ref_calc(op, a, b, res, sp);
        op_start   = cyc;
        pend_start = cyc;
        pend_done  = cyc + 1 + (sp ? 0 : XLEN + 1);
        pend_data  = res;
        pend_wd    = wd;
        pend_wreg  = wreg;
        pend_live  = 1;
        kk = (k > pend_done - op_start) ? pend_done - op_start : k;
        bus.op_i = op; bus.opr1_i = a; bus.opr2_i = b; bus.wd_i = wd; bus.wreg_i = wreg;
        bus.start_i = 1'b1;
        for (int r = 0; r < 100; r++) begin
            if (mode == 2 && cyc - op_start == kk) bus.flush_i = 1'b1;
            if (mode == 3 && cyc - op_start == kk) rst = 1'b1;
            @(posedge clk);
            #1;
            if (bus.flush_i) begin
                bus.flush_i = 1'b0;
                bus.start_i = 1'b0;
                pend_live   = 0;
                return;
            end
            if (rst) begin
                rst = 1'b0;
                bus.start_i = 1'b0;
                pend_live   = 0;
                last_wdata  = '0;
                last_wd     = '0;
                return;
            end
            if (r == 0 && mode != 1) begin
                bus.start_i = 1'b0;
                bus.op_i    = 3'($urandom);
                bus.opr1_i  = $urandom;
                bus.opr2_i  = $urandom;
                bus.wd_i    = RW'($urandom);
            end
            if (!pend_live) begin
                bus.start_i = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("op_timeout", 64'(pend_live), 64'd0);
        pend_live = 0;
        bus.start_i = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] r;
        bit          sp;
        int          st;
        bus.start_i = 0; bus.op_i = 0; bus.opr1_i = 0; bus.opr2_i = 0;
        bus.wd_i = 0; bus.wreg_i = 0; bus.flush_i = 0;

        vecs = '{
            '{3'd0, 32'h7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
            '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
            '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
            '{3'd2, 32'hFFFF_FFFF,  32'h2,         32'hFFFF_FFFF},
            '{3'd4, 32'hFFFF_FFF9,  32'h2,         32'hFFFF_FFFD},
            '{3'd6, 32'hFFFF_FFF9,  32'h2,         32'hFFFF_FFFF},
            '{3'd5, 32'd100,        32'd7,         32'd14},
            '{3'd7, 32'd100,        32'd7,         32'd2},
            '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF},
            '{3'd6, 32'd5,          32'd0,         32'd5},
            '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
            '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0}
        };
        foreach (vecs[i]) begin
            ref_calc(vecs[i].op, vecs[i].a, vecs[i].b, r, sp);
            chk($sformatf("model_vec%0d", i), r, vecs[i].exp);
        end

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #3;
        chk("rst_stall", bus.ex_stall_o, 1'b0);
        chk("rst_done", bus.done_o, 1'b0);
        chk("rst_wdata", bus.wdata_o, 32'h0);

        run_op(3'd0, 32'h7, 32'hFFFF_FFFD, 5'd5, 1'b1, 0, 0);
        chk("mul_lit", bus.wdata_o, 32'hFFFF_FFEB);
        chk("mul_wd", bus.wd_o, 5'd5);
        chk("mul_latency", done_seen_cyc - op_start, 34);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, RW'(i), 1'b1, 0, 0);
            chk($sformatf("dut_vec%0d", i), bus.wdata_o, vecs[i].exp);
        end

        run_op(3'd5, 32'd5, 32'd0, 5'd3, 1'b1, 0, 0);
        chk("divz_latency", done_seen_cyc - op_start, 1);

        // Flush mid-divide, then a fresh multiply two cycles later
        run_op(3'd4, 32'd1000, 32'd7, 5'd4, 1'b1, 2, 10);
        st = op_start;
        @(posedge clk);
        chk("flush_no_done", 64'(done_seen_cyc < st), 64'd1);
        run_op(3'd0, 32'd3, 32'd4, 5'd6, 1'b1, 0, 0);
        chk("after_flush_mul", bus.wdata_o, 32'd12);

        // Flush during the done cycle suppresses wreg_o only
        run_op(3'd5, 32'd100, 32'd7, 5'd9, 1'b1, 2, 34);
        chk("flushdone_latency", done_seen_cyc - op_start, 34);

        // Reset in the middle of a divide
        run_op(3'd4, 32'd12345, 32'd17, 5'd7, 1'b1, 3, 20);
        @(negedge clk);
        #3;
        chk("midrst_wdata", bus.wdata_o, 32'h0);
        chk("midrst_wd", bus.wd_o, 5'd0);
        chk("midrst_stall", bus.ex_stall_o, 1'b0);

        // start_i held high for the whole operation
        run_op(3'd7, 32'd100, 32'd7, 5'd11, 1'b1, 1, 0);
        chk("hold_result", bus.wdata_o, 32'd2);

        for (int n = 0; n < 45; n++) begin
            int m, k;
            m = $urandom_range(0, 9);
            k = $urandom_range(0, 36);
            run_op(3'($urandom), pick(), pick(), RW'($urandom), 1'($urandom),
                   (m < 7) ? 0 : (m == 7) ? 1 : (m == 8) ? 2 : 3, k);
            if ($urandom_range(0, 3) == 0) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
